// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Shift-add multiply and restoring divide, one bit per cycle, with sign fix-up.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic [ADDR_WIDTH-1:0] rd_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [ADDR_WIDTH-1:0] rd_out,
    output logic                  we_out
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, next_state;

    logic [2:0]     op;
    logic           neg_a, neg_b;
    logic [W-1:0]   mag_a, mag_b;
    logic [2*W-1:0] acc;
    logic [CW-1:0]  count;

    logic           is_div, sgn_a, sgn_b, in_neg_a, in_neg_b;
    logic [W-1:0]   in_mag_a, in_mag_b;
    logic           div_zero, ovf, fast;
    logic [W-1:0]   fast_val;
    logic [W:0]     mul_sum, div_sh, div_diff;
    logic           div_ge;
    logic [2*W-1:0] mul_next, div_next, prod;
    logic [W-1:0]   quo, rem, fix_val;

    // Operand decode: signedness, magnitudes and the divide fast-path cases.
    always_comb begin
        is_div   = funct3[2];
        sgn_a    = funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
        sgn_b    = funct3 inside {3'b001, 3'b100, 3'b110};
        in_neg_a = sgn_a & op_a[W-1];
        in_neg_b = sgn_b & op_b[W-1];
        in_mag_a = in_neg_a ? -op_a : op_a;
        in_mag_b = in_neg_b ? -op_b : op_b;
        div_zero = is_div && (op_b == '0);
        ovf      = (funct3 == 3'b100 || funct3 == 3'b110)
                   && (op_a == {1'b1, {(W-1){1'b0}}})
                   && (&op_b);
        fast     = div_zero | ovf;
        if (div_zero)
            fast_val = funct3[1] ? op_a : '1;
        else
            fast_val = funct3[1] ? '0 : op_a;
    end

    // One iteration of shift-add multiply and restoring divide on acc.
    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_a} : '0);
        mul_next = {mul_sum, acc[W-1:1]};
        div_sh   = {acc[2*W-1:W], acc[W-1]};
        div_ge   = div_sh >= {1'b0, mag_b};
        div_diff = div_sh - {1'b0, mag_b};
        div_next = {div_ge ? div_diff[W-1:0] : div_sh[W-1:0],
                    acc[W-2:0], div_ge};
    end

    // Sign correction and result selection by opcode.
    always_comb begin
        prod = (neg_a ^ neg_b) ? -acc : acc;
        quo  = (neg_a ^ neg_b) ? -acc[W-1:0] : acc[W-1:0];
        rem  = neg_a ? -acc[2*W-1:W] : acc[2*W-1:W];
        unique case (op)
            3'b000:                 fix_val = prod[W-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod[2*W-1:W];
            3'b100, 3'b101:         fix_val = quo;
            default:                fix_val = rem;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = fast ? DONE : CALC;
            CALC:    if (count == LAST) next_state = FIX;
            FIX:     next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op     <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            acc    <= '0;
            count  <= '0;
            result <= '0;
            rd_out <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    op     <= funct3;
                    rd_out <= rd_in;
                    neg_a  <= in_neg_a;
                    neg_b  <= in_neg_b;
                    mag_a  <= in_mag_a;
                    mag_b  <= in_mag_b;
                    count  <= '0;
                    acc    <= is_div ? {{W{1'b0}}, in_mag_a}
                                     : {{W{1'b0}}, in_mag_b};
                    if (fast) result <= fast_val;
                end
                CALC: begin
                    acc   <= op[2] ? div_next : mul_next;
                    count <= count + 1'b1;
                end
                FIX:     result <= fix_val;
                default: ;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign we_out = done && (rd_out != '0);

endmodule
